// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
// Divider hardware exists only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

   localparam int DW_DEFAULT = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10
   } state_e;

   function automatic logic op_signed(input logic [1:0] o);
      return ~o[0];
   endfunction

   function automatic logic op_is_div(input logic [1:0] o);
      return o[1];
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; used both to take operand
// magnitudes and to restore the sign of results.
module muldiv_sign_fix #(
   parameter int W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   output logic [W-1:0] res_o
);

   assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Radix-2 iterative mult/div engine owning the HI/LO pair.
// Define MULDIV_DIV_EN to build the restoring divider.
module hilo_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter  int DATA_WIDTH = DW_DEFAULT,
   localparam int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   input  logic                  hi_we,
   input  logic                  lo_we,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] HI,
   output logic [DATA_WIDTH-1:0] LO
);

   localparam int DW = DATA_WIDTH;

   state_e           state_q;
   logic             div_q;
   logic             pneg_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2*DW-1:0]  acc_q;
   logic [DW-1:0]    a_q;
   logic [DW-1:0]    hi_q, lo_q;
   logic             busy_q, done_q;

   logic          neg_a, neg_b;
   logic [DW-1:0] mag_a, mag_b;

   assign neg_a = op_signed(op) & SrcA[DW-1];
   assign neg_b = op_signed(op) & SrcB[DW-1];

   muldiv_sign_fix #(.W(DW)) u_abs_a (
      .val_i(SrcA), .neg_i(neg_a), .res_o(mag_a)
   );

   muldiv_sign_fix #(.W(DW)) u_abs_b (
      .val_i(SrcB), .neg_i(neg_b), .res_o(mag_b)
   );

   // Shift-add: multiplier sits in the low half and drains out the bottom.
   logic [DW:0]     add_sum;
   logic [2*DW-1:0] mul_nxt;
   logic [2*DW-1:0] prod_fix;
   logic [2*DW-1:0] step;

   assign add_sum = {1'b0, acc_q[2*DW-1:DW]} + {1'b0, a_q};
   assign mul_nxt = acc_q[0] ? {add_sum, acc_q[DW-1:1]}
                             : {1'b0, acc_q[2*DW-1:1]};

   muldiv_sign_fix #(.W(2*DW)) u_fix_p (
      .val_i(acc_q), .neg_i(pneg_q), .res_o(prod_fix)
   );

`ifdef MULDIV_DIV_EN
   logic [DW-1:0]   b_q;
   logic            rneg_q, bz_q;
   logic [DW:0]     rem_sh, sub;
   logic [2*DW-1:0] div_nxt;
   logic [DW-1:0]   rem_in, rem_fix;

   // Restoring step: remainder in the high half, quotient shifts in low.
   assign rem_sh  = acc_q[2*DW-1:DW-1];
   assign sub     = rem_sh - {1'b0, b_q};
   assign div_nxt = sub[DW] ? {rem_sh[DW-1:0], acc_q[DW-2:0], 1'b0}
                            : {sub[DW-1:0], acc_q[DW-2:0], 1'b1};
   assign step    = div_q ? div_nxt : mul_nxt;
   assign rem_in  = bz_q ? a_q : acc_q[2*DW-1:DW];

   muldiv_sign_fix #(.W(DW)) u_fix_r (
      .val_i(rem_in), .neg_i(rneg_q), .res_o(rem_fix)
   );
`else
   assign step = mul_nxt;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         div_q   <= 1'b0;
         pneg_q  <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
         b_q     <= '0;
         rneg_q  <= 1'b0;
         bz_q    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (hi_we) hi_q <= wdata;
               if (lo_we) lo_q <= wdata;
               if (start) begin
                  div_q  <= op_is_div(op);
                  pneg_q <= neg_a ^ neg_b;
                  a_q    <= mag_a;
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
`ifdef MULDIV_DIV_EN
                  b_q     <= mag_b;
                  rneg_q  <= neg_a;
                  bz_q    <= (SrcB == '0);
                  acc_q   <= op_is_div(op) ? {{DW{1'b0}}, mag_a}
                                           : {{DW{1'b0}}, mag_b};
                  state_q <= S_RUN;
`else
                  acc_q   <= {{DW{1'b0}}, mag_b};
                  state_q <= op_is_div(op) ? S_FIX : S_RUN;
`endif
               end
            end
            S_RUN: begin
               acc_q <= step;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DW - 1)) state_q <= S_FIX;
            end
            S_FIX: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               if (!div_q) begin
                  hi_q <= prod_fix[2*DW-1:DW];
                  lo_q <= prod_fix[DW-1:0];
               end
`ifdef MULDIV_DIV_EN
               else begin
                  hi_q <= rem_fix;
                  lo_q <= bz_q ? '1 : prod_fix[DW-1:0];
               end
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed plus random checks of hilo_muldiv_unit against an
// arithmetic reference model (honours MULDIV_DIV_EN).
module tb_hilo_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset, start, hi_we, lo_we;
   logic [1:0]  op;
   logic [31:0] SrcA, SrcB, wdata;
   logic        busy, done;
   logic [31:0] HI, LO;

   int checks = 0;
   int errors = 0;
   logic [31:0] hi_m = '0;
   logic [31:0] lo_m = '0;

   hilo_muldiv_unit dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .SrcA(SrcA), .SrcB(SrcB), .hi_we(hi_we), .lo_we(lo_we),
      .wdata(wdata), .busy(busy), .done(done), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b,
                        output logic [31:0] eh, output logic [31:0] el,
                        output bit upd, output int lat);
      longint sa, sb;
      logic [63:0] p;
      int q, r;
      upd = 1; lat = 34; eh = hi_m; el = lo_m;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'b00: begin p = 64'(sa * sb); {eh, el} = p; end
         2'b01: begin p = {32'h0, a} * {32'h0, b}; {eh, el} = p; end
         2'b10: begin
            if (b == 0) begin eh = a; el = '1; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               eh = 0; el = 32'h8000_0000;
            end else begin
               q = $signed(a) / $signed(b);
               r = $signed(a) % $signed(b);
               eh = r; el = q;
            end
         end
         default: begin
            if (b == 0) begin eh = a; el = '1; end
            else begin eh = a % b; el = a / b; end
         end
      endcase
`ifndef MULDIV_DIV_EN
      if (o[1]) begin upd = 0; lat = 2; eh = hi_m; el = lo_m; end
`endif
   endtask

   // Called right after a negedge; returns at the negedge of the done cycle.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int inj,
                         input bit we0, input string tag);
      logic [31:0] eh, el;
      bit upd, got, held;
      int lat, n, nb;
      model(o, a, b, eh, el, upd, lat);
      op = o; SrcA = a; SrcB = b; start = 1;
      if (we0) begin lo_we = 1; wdata = 32'hA5A5_0F0F; end
      @(posedge clk); #1;
      start = 0; lo_we = 0;
      if (we0) lo_m = 32'hA5A5_0F0F;
      n = 0; nb = 0; got = 0; held = 1;
      while (!got && n < 200) begin
         @(negedge clk);
         n++;
         if (busy === 1'b1) nb++;
         if (done === 1'b1) got = 1;
         else if (HI !== hi_m || LO !== lo_m) held = 0;
         if (n == inj) begin
            start = 1; lo_we = 1; wdata = 32'h55; op = 2'b00;
         end else if (n == inj + 1) begin
            start = 0; lo_we = 0;
         end
         SrcA = $urandom; SrcB = $urandom;
      end
      start = 0; lo_we = 0;
      if (upd) begin hi_m = eh; lo_m = el; end
      chk({tag, " latency"}, n, lat);
      chk({tag, " busycnt"}, nb, lat - 1);
      chk({tag, " hold"}, held, 1'b1);
      chk({tag, " HI"}, HI, hi_m);
      chk({tag, " LO"}, LO, lo_m);
   endtask

   initial begin
      int n;
      bit saw;
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      reset = 1; start = 0; hi_we = 0; lo_we = 0;
      op = 0; SrcA = 0; SrcB = 0; wdata = 0;
      repeat (2) @(negedge clk);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst HI", HI, 0);
      chk("rst LO", LO, 0);
      reset = 0;
      @(negedge clk);

      hi_we = 1; wdata = 32'h1234;
      @(negedge clk);
      hi_we = 0;
      hi_m = 32'h1234;
      chk("mthi HI", HI, hi_m);
      chk("mthi LO", LO, lo_m);
      lo_we = 1; wdata = 32'hBEEF;
      @(negedge clk);
      lo_we = 0;
      lo_m = 32'hBEEF;
      chk("mtlo LO", LO, lo_m);

      run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0, 0, "multu max*2");
      chk("multu HI const", HI, 32'h1);
      chk("multu LO const", LO, 32'hFFFF_FFFE);
      @(negedge clk);
      chk("done pulse", done, 0);
      run_op(2'b00, -32'sd3, 32'd5, 0, 0, "mult -3*5");
      chk("mult LO const", LO, 32'hFFFF_FFF1);
      run_op(2'b01, 32'd7, 32'd6, 5, 0, "multu ignore");
      chk("ignore LO const", LO, 32'd42);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0, "mult min*min");
      run_op(2'b01, 32'd3, 32'd4, 0, 1, "same-edge we");
      run_op(2'b10, -32'sd7, 32'd2, 0, 0, "div -7/2");
      run_op(2'b11, 32'd9, 32'd0, 0, 0, "divu 9/0");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div ovf");
      run_op(2'b10, -32'sd5, 32'd0, 0, 0, "div -5/0");
      run_op(2'b11, 32'd10, 32'd3, 0, 0, "divu 10/3");

      for (int i = 0; i < 24; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 9));
            default: ;
         endcase
         run_op(ro, ra, rb, 0, 0, "random");
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

`ifdef MULDIV_DIV_EN
      op = 2'b10;
`else
      op = 2'b00;
`endif
      SrcA = 32'd100; SrcB = 32'd7; start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (9) @(negedge clk);
      reset = 1;
      @(negedge clk);
      hi_m = 0; lo_m = 0;
      chk("midrst busy", busy, 0);
      chk("midrst done", done, 0);
      chk("midrst HI", HI, hi_m);
      chk("midrst LO", LO, lo_m);
      reset = 0;
      saw = 0; n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (done === 1'b1 || busy === 1'b1) saw = 1;
      end
      chk("midrst quiet", saw, 0);
      chk("midrst HI hold", HI, hi_m);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
